i3c_daa_seq: RTL and testbench
==============================

Name: i3c_daa_seq

Overview:
- Sequencer for the slave ENTDAA datapath.
- Tracks the ENTDAA round structure: 7E/R header, 64-bit ID/BCR/DCR arbitration, 7-bit DA plus parity, then ACK/NACK.
- Drives daa_active and the id64_cnt bit counter consumed by the DAA datapath. Detects arbitration loss and re-arms on every repeated START until a DA is held or the CCC exits.
- Sits between the CCC engine (header/Sr/CCC state) and the DAA datapath, all on clk_SCL rising edge.

Parameters:
- MAX_RETRY, 3, parity-NACK retries tolerated before giving up (used only with I3C_DAA_RETRY_CNT_EN).
- RETRY_W, 2, width of the retry counter; must hold MAX_RETRY.

Ports:
- clk_SCL  input  1  SCL rising edge; all state updates
- RSTn  input  1  reset, asynchronous, active-low
- entdaa_ccc  input  1  level: engine CCC state is ENTDAA; low = exit/abort
- sr_det  input  1  level: repeated START seen since last SCL edge (engine-held until next edge)
- hdr_ack  input  1  one-cycle: 7E/R header ACKed by this slave; first ID bit follows
- da_assigned  input  1  dyn_addr[0] from datapath
- pin_SDA_in  input  1  sampled SDA
- daa_inp_drv  input  1  datapath is driving
- daa_inp_bit  input  1  value datapath drives (1 = released, open-drain)
- parity_ok  input  1  datapath parity match on received DA
- daa_active  output  1  round in progress for this slave
- id64_cnt  output  7  bit counter to datapath
- daa_lost  output  1  arbitration lost this round (level until next Sr)
- daa_win  output  1  one-cycle pulse: ACK of a valid DA
- daa_state  output  3  encoded state for debug/CCC engine

Behaviour:
- Reset: state IDLE; daa_active=0, id64_cnt=7'h7F, daa_lost=0, daa_win=0, daa_state=0.
- States and codes: IDLE=0, WAIT_HDR=1, ID=2, DA=3, ACK=4, LOST=5, DONE=6.
- IDLE -> WAIT_HDR when entdaa_ccc & ~da_assigned.
- WAIT_HDR:
  - hdr_ack -> ID, daa_active=1, id64_cnt=7'h7F.
  - sr_det alone stays in WAIT_HDR.
- ID:
  - Counter decrements each edge, 7'h7F down to 7'h40; ID bit = id64_cnt[5:0].
  - Loss check at every ID edge: daa_inp_drv & daa_inp_bit & ~pin_SDA_in.
  - On loss -> LOST: daa_active=0, daa_lost=1.
  - After the 7'h40 edge, counter loads 7'h0F and state -> DA.
- DA:
  - Counter decrements 7'h0F..7'h08. Bits [2:0]=7..1 are address bits, 7'h08 is parity.
  - Then counter -> 7'h07 and state -> ACK.
- ACK (one edge, id64_cnt=7'h07):
  - parity_ok: daa_win pulses 1 for this cycle -> DONE, daa_active=0.
  - ~parity_ok: -> WAIT_HDR, daa_active=0; the slave re-competes after the next Sr.
- LOST: sr_det -> WAIT_HDR, daa_lost cleared; the master re-arbitrates among slaves still without a DA.
- DONE: holds until entdaa_ccc=0 -> IDLE.
- Abort: entdaa_ccc=0 in any state -> IDLE next edge; counter reset to 7'h7F, daa_lost=0. Abort has priority over all other transitions.
- da_assigned rising while in WAIT_HDR (e.g. via SETDASA race) -> DONE.
- Counter never wraps. Any counter value outside the state's range forces IDLE (defensive).
- sr_det in ID/DA/ACK (master restart mid-round) -> WAIT_HDR, daa_active=0.
- Latency: daa_active rises on the same edge that samples hdr_ack; the first ID bit is driven on the following falling edge.

Optional Feature:
- Macro: I3C_DAA_RETRY_CNT_EN.
- With the macro:
  - Counter of consecutive parity NACKs, cleared on daa_win or on entering IDLE.
  - Reaching MAX_RETRY moves the block to DONE without an address, so it stops competing.
  - Extra output daa_retry_gaveup (level, cleared in IDLE).
- Without the macro: unlimited retries, no extra port.

Decomposition:
- Shared package: state encodings, counter constants (CNT_ID_FIRST=7'h7F, CNT_ID_LAST=7'h40, CNT_DA_FIRST=7'h0F, CNT_PAR=7'h08, CNT_ACK=7'h07), plus DAA_ST_* codes reused by the CCC engine.
- One natural sub-module, i3c_daa_bitcnt: loadable down-counter with load/decrement/phase-end flags.

Test Plan:
- Win round: entdaa_ccc=1, hdr_ack, SDA mirrors driven ID for 64 edges, DA=7'h0A with correct parity -> counter 7F..40, 0F..08, 07; daa_win pulse at 07; state DONE.
- Loss at bit 7'h50: driven 1, SDA=0 -> daa_lost=1, daa_active=0 next edge; then sr_det + hdr_ack -> ID restarts at 7'h7F.
- Parity bad: wrong parity at 7'h08 -> no daa_win; WAIT_HDR; the next round wins.
- Abort: entdaa_ccc drops at counter 7'h0C -> IDLE, id64_cnt=7'h7F, daa_active=0.
- Reset mid-ID at 7'h60 -> all outputs at reset values immediately, asynchronously.
- With I3C_DAA_RETRY_CNT_EN and MAX_RETRY=3: three bad-parity rounds -> daa_retry_gaveup=1, DONE, no daa_win.

Source files
------------

// File: rtl/i3c_daa_seq_pkg.sv
// Shared definitions for the slave ENTDAA sequencer: state codes, bit-counter
// landmarks and counter range helpers. DAA_ST_* codes are also consumed by the
// CCC engine for debug and status decode.
package i3c_daa_seq_pkg;

    localparam int unsigned CNT_W = 7;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] DAA_ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] DAA_ST_WAIT_HDR = 3'd1;
    localparam logic [ST_W-1:0] DAA_ST_ID       = 3'd2;
    localparam logic [ST_W-1:0] DAA_ST_DA       = 3'd3;
    localparam logic [ST_W-1:0] DAA_ST_ACK      = 3'd4;
    localparam logic [ST_W-1:0] DAA_ST_LOST     = 3'd5;
    localparam logic [ST_W-1:0] DAA_ST_DONE     = 3'd6;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = DAA_ST_IDLE,
        ST_WAIT_HDR = DAA_ST_WAIT_HDR,
        ST_ID       = DAA_ST_ID,
        ST_DA       = DAA_ST_DA,
        ST_ACK      = DAA_ST_ACK,
        ST_LOST     = DAA_ST_LOST,
        ST_DONE     = DAA_ST_DONE
    } daa_state_e;

    localparam logic [CNT_W-1:0] CNT_ID_FIRST = 7'h7F;
    localparam logic [CNT_W-1:0] CNT_ID_LAST  = 7'h40;
    localparam logic [CNT_W-1:0] CNT_DA_FIRST = 7'h0F;
    localparam logic [CNT_W-1:0] CNT_PAR      = 7'h08;
    localparam logic [CNT_W-1:0] CNT_ACK      = 7'h07;

    // Counter values legal while shifting the 64-bit ID/BCR/DCR field.
    function automatic logic cnt_in_id(input logic [CNT_W-1:0] c);
        return (c >= CNT_ID_LAST);
    endfunction

    // Counter values legal while receiving the DA and its parity bit.
    function automatic logic cnt_in_da(input logic [CNT_W-1:0] c);
        return (c >= CNT_PAR) && (c <= CNT_DA_FIRST);
    endfunction

endpackage

// File: rtl/i3c_daa_seq_bitcnt.sv
// Loadable, non-wrapping down-counter that provides id64_cnt to the DAA
// datapath, with combinational flags marking the last ID bit and the parity bit.
module i3c_daa_bitcnt
    import i3c_daa_seq_pkg::*;
(
    input  logic             clk_SCL,
    input  logic             RSTn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_id_last_c,
    output logic             o_par_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement; the counter saturates at zero.
    always_ff @(posedge clk_SCL or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= CNT_ID_FIRST;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt       = r_cnt;
    assign o_id_last_c = (r_cnt == CNT_ID_LAST);
    assign o_par_c     = (r_cnt == CNT_PAR);

endmodule

// File: rtl/i3c_daa_seq.sv
// Slave ENTDAA round sequencer: follows 7E/R header, 64-bit ID arbitration,
// DA + parity and ACK, tracking arbitration loss and re-arming on repeated START.
// Optional macro I3C_DAA_RETRY_CNT_EN limits consecutive parity NACKs to
// MAX_RETRY and adds the daa_retry_gaveup output.
module i3c_daa_seq
    import i3c_daa_seq_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_W   = 2
) (
    input  logic             clk_SCL,
    input  logic             RSTn,
    input  logic             entdaa_ccc,
    input  logic             sr_det,
    input  logic             hdr_ack,
    input  logic             da_assigned,
    input  logic             pin_SDA_in,
    input  logic             daa_inp_drv,
    input  logic             daa_inp_bit,
    input  logic             parity_ok,
    output logic             daa_active,
    output logic [CNT_W-1:0] id64_cnt,
    output logic             daa_lost,
    output logic             daa_win,
    output logic [ST_W-1:0]  daa_state
`ifdef I3C_DAA_RETRY_CNT_EN
    ,
    output logic             daa_retry_gaveup
`endif
);

    // Retry counter must be able to represent MAX_RETRY.
    if (MAX_RETRY >= (32'd1 << RETRY_W)) begin : g_retry_w_too_narrow
        $error("i3c_daa_seq: RETRY_W cannot hold MAX_RETRY");
    end

    daa_state_e       r_state;
    daa_state_e       w_state_nxt;
    logic             r_active;
    logic             r_lost;
    logic             r_win;
    logic             w_active_nxt;
    logic             w_lost_nxt;
    logic             w_win_nxt;
    logic             w_go_idle;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_ld_val;
    logic             w_cnt_dec;
    logic [CNT_W-1:0] w_cnt;
    logic             w_id_last;
    logic             w_par;
    logic             w_loss;

`ifdef I3C_DAA_RETRY_CNT_EN
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;
    logic               r_gaveup;
    logic               w_gaveup_nxt;
`endif

    // We released SDA (drove 1) but the bus reads 0: another slave wins this bit.
    assign w_loss = daa_inp_drv & daa_inp_bit & ~pin_SDA_in;

    i3c_daa_bitcnt u_bitcnt (
        .clk_SCL     (clk_SCL),
        .RSTn        (RSTn),
        .i_load      (w_cnt_load),
        .i_load_val  (w_cnt_ld_val),
        .i_dec       (w_cnt_dec),
        .o_cnt       (w_cnt),
        .o_id_last_c (w_id_last),
        .o_par_c     (w_par)
    );

    // State and registered outputs.
    always_ff @(posedge clk_SCL or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_lost   <= 1'b0;
            r_win    <= 1'b0;
`ifdef I3C_DAA_RETRY_CNT_EN
            r_retry  <= '0;
            r_gaveup <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_lost   <= w_lost_nxt;
            r_win    <= w_win_nxt;
`ifdef I3C_DAA_RETRY_CNT_EN
            r_retry  <= w_retry_nxt;
            r_gaveup <= w_gaveup_nxt;
`endif
        end
    end

    // Next-state, counter control and next output values; abort overrides all.
    always_comb begin
        w_state_nxt  = r_state;
        w_go_idle    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_ld_val = CNT_ID_FIRST;
        w_cnt_dec    = 1'b0;
        w_active_nxt = r_active;
        w_lost_nxt   = r_lost;
        w_win_nxt    = 1'b0;
`ifdef I3C_DAA_RETRY_CNT_EN
        w_retry_nxt  = r_retry;
        w_gaveup_nxt = r_gaveup;
`endif
        if (!entdaa_ccc) begin
            w_go_idle = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef I3C_DAA_RETRY_CNT_EN
                    w_retry_nxt  = '0;
                    w_gaveup_nxt = 1'b0;
`endif
                    if (!da_assigned) begin
                        w_state_nxt = ST_WAIT_HDR;
                    end
                end
                ST_WAIT_HDR: begin
                    if (da_assigned) begin
                        w_state_nxt = ST_DONE;
                    end else if (hdr_ack) begin
                        w_state_nxt  = ST_ID;
                        w_cnt_load   = 1'b1;
                        w_active_nxt = 1'b1;
                    end
                end
                ST_ID: begin
                    if (!cnt_in_id(w_cnt)) begin
                        w_go_idle = 1'b1;
                    end else if (sr_det) begin
                        w_state_nxt  = ST_WAIT_HDR;
                        w_cnt_load   = 1'b1;
                        w_active_nxt = 1'b0;
                    end else if (w_loss) begin
                        w_state_nxt  = ST_LOST;
                        w_active_nxt = 1'b0;
                        w_lost_nxt   = 1'b1;
                    end else if (w_id_last) begin
                        w_state_nxt  = ST_DA;
                        w_cnt_load   = 1'b1;
                        w_cnt_ld_val = CNT_DA_FIRST;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_DA: begin
                    if (!cnt_in_da(w_cnt)) begin
                        w_go_idle = 1'b1;
                    end else if (sr_det) begin
                        w_state_nxt  = ST_WAIT_HDR;
                        w_cnt_load   = 1'b1;
                        w_active_nxt = 1'b0;
                    end else begin
                        w_cnt_dec = 1'b1;
                        if (w_par) begin
                            w_state_nxt = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (w_cnt != CNT_ACK) begin
                        w_go_idle = 1'b1;
                    end else if (sr_det) begin
                        w_state_nxt  = ST_WAIT_HDR;
                        w_cnt_load   = 1'b1;
                        w_active_nxt = 1'b0;
                    end else if (parity_ok) begin
                        w_state_nxt  = ST_DONE;
                        w_active_nxt = 1'b0;
                        w_win_nxt    = 1'b1;
`ifdef I3C_DAA_RETRY_CNT_EN
                        w_retry_nxt  = '0;
`endif
                    end else begin
                        w_active_nxt = 1'b0;
`ifdef I3C_DAA_RETRY_CNT_EN
                        if (r_retry >= RETRY_W'(MAX_RETRY - 1)) begin
                            w_state_nxt  = ST_DONE;
                            w_gaveup_nxt = 1'b1;
                            w_retry_nxt  = RETRY_W'(MAX_RETRY);
                        end else begin
                            w_state_nxt = ST_WAIT_HDR;
                            w_cnt_load  = 1'b1;
                            w_retry_nxt = r_retry + RETRY_W'(1);
                        end
`else
                        w_state_nxt = ST_WAIT_HDR;
                        w_cnt_load  = 1'b1;
`endif
                    end
                end
                ST_LOST: begin
                    if (sr_det) begin
                        w_state_nxt = ST_WAIT_HDR;
                        w_cnt_load  = 1'b1;
                        w_lost_nxt  = 1'b0;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    w_go_idle = 1'b1;
                end
            endcase
        end

        if (w_go_idle) begin
            w_state_nxt  = ST_IDLE;
            w_cnt_load   = 1'b1;
            w_cnt_ld_val = CNT_ID_FIRST;
            w_cnt_dec    = 1'b0;
            w_active_nxt = 1'b0;
            w_lost_nxt   = 1'b0;
            w_win_nxt    = 1'b0;
`ifdef I3C_DAA_RETRY_CNT_EN
            w_retry_nxt  = '0;
            w_gaveup_nxt = 1'b0;
`endif
        end
    end

    assign daa_active = r_active;
    assign id64_cnt   = w_cnt;
    assign daa_lost   = r_lost;
    assign daa_win    = r_win;
    assign daa_state  = r_state;
`ifdef I3C_DAA_RETRY_CNT_EN
    assign daa_retry_gaveup = r_gaveup;
`endif

endmodule

// File: tb/tb_i3c_daa_seq.sv
// Self-checking bench for i3c_daa_seq: constant vector table, directed round
// sequences and randomized traffic against a position-based round model.
// Define I3C_DAA_RETRY_CNT_EN to also cover the retry-limit feature.
module tb_i3c_daa_seq;

    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_ID   = 2;
    localparam int S_DA   = 3;
    localparam int S_ACK  = 4;
    localparam int S_LOST = 5;
    localparam int S_DONE = 6;
    localparam int MAXR   = 3;

    logic       clk_SCL = 1'b0;
    logic       RSTn;
    logic       entdaa_ccc, sr_det, hdr_ack, da_assigned;
    logic       pin_SDA_in, daa_inp_drv, daa_inp_bit, parity_ok;
    logic       daa_active, daa_lost, daa_win;
    logic [6:0] id64_cnt;
    logic [2:0] daa_state;
`ifdef I3C_DAA_RETRY_CNT_EN
    logic       daa_retry_gaveup;
`endif

    i3c_daa_seq #(.MAX_RETRY(3), .RETRY_W(2)) dut (
        .clk_SCL     (clk_SCL),
        .RSTn        (RSTn),
        .entdaa_ccc  (entdaa_ccc),
        .sr_det      (sr_det),
        .hdr_ack     (hdr_ack),
        .da_assigned (da_assigned),
        .pin_SDA_in  (pin_SDA_in),
        .daa_inp_drv (daa_inp_drv),
        .daa_inp_bit (daa_inp_bit),
        .parity_ok   (parity_ok),
        .daa_active  (daa_active),
        .id64_cnt    (id64_cnt),
        .daa_lost    (daa_lost),
        .daa_win     (daa_win),
        .daa_state   (daa_state)
`ifdef I3C_DAA_RETRY_CNT_EN
        ,
        .daa_retry_gaveup (daa_retry_gaveup)
`endif
    );

    always #5 clk_SCL = ~clk_SCL;

    typedef struct packed {
        logic ccc, sr, hdr, das, sda, drv, dbit, par;
    } in_t;

    typedef struct {
        in_t  in;
        int   st;
        int   cnt;
        logic act, lost, win;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;

    // Round model: position in the round (0..63 ID bits, 64..71 DA+parity, 72 ACK).
    int   m_state = S_IDLE;
    int   m_pos   = 0;
    logic m_act   = 1'b0;
    logic m_lost  = 1'b0;
    logic m_win   = 1'b0;
    int   m_retry = 0;
    logic m_gave  = 1'b0;

    function automatic in_t mk(input logic ccc, sr, hdr, das, sda, drv, dbit, par);
        in_t v;
        v.ccc = ccc; v.sr = sr; v.hdr = hdr; v.das = das;
        v.sda = sda; v.drv = drv; v.dbit = dbit; v.par = par;
        return v;
    endfunction

    function automatic int cnt_of_pos(input int pos);
        if (pos < 64) return 127 - pos;
        if (pos < 72) return 15 - (pos - 64);
        return 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_pos = 0; m_act = 1'b0; m_lost = 1'b0;
        m_win = 1'b0; m_retry = 0; m_gave = 1'b0;
    endtask

    task automatic model_step(input in_t v);
        m_win = 1'b0;
        if (!v.ccc) begin
            m_state = S_IDLE; m_pos = 0; m_act = 1'b0; m_lost = 1'b0;
            m_retry = 0; m_gave = 1'b0;
        end else begin
            case (m_state)
                S_IDLE: begin
                    m_retry = 0; m_gave = 1'b0;
                    if (!v.das) m_state = S_WAIT;
                end
                S_WAIT: begin
                    if (v.das) m_state = S_DONE;
                    else if (v.hdr) begin m_state = S_ID; m_pos = 0; m_act = 1'b1; end
                end
                S_ID, S_DA, S_ACK: begin
                    if (v.sr) begin
                        m_state = S_WAIT; m_pos = 0; m_act = 1'b0;
                    end else if (m_state == S_ID) begin
                        if (v.drv && v.dbit && !v.sda) begin
                            m_state = S_LOST; m_act = 1'b0; m_lost = 1'b1;
                        end else begin
                            m_pos++;
                            if (m_pos == 64) m_state = S_DA;
                        end
                    end else if (m_state == S_DA) begin
                        m_pos++;
                        if (m_pos == 72) m_state = S_ACK;
                    end else begin
                        m_act = 1'b0;
                        if (v.par) begin
                            m_win = 1'b1; m_state = S_DONE; m_retry = 0;
                        end else begin
`ifdef I3C_DAA_RETRY_CNT_EN
                            m_retry++;
                            if (m_retry >= MAXR) begin m_state = S_DONE; m_gave = 1'b1; end
                            else begin m_state = S_WAIT; m_pos = 0; end
`else
                            m_state = S_WAIT; m_pos = 0;
`endif
                        end
                    end
                end
                S_LOST: begin
                    if (v.sr) begin m_state = S_WAIT; m_pos = 0; m_lost = 1'b0; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input in_t v);
        entdaa_ccc = v.ccc; sr_det = v.sr; hdr_ack = v.hdr; da_assigned = v.das;
        pin_SDA_in = v.sda; daa_inp_drv = v.drv; daa_inp_bit = v.dbit; parity_ok = v.par;
    endtask

    task automatic apply(input in_t v);
        @(negedge clk_SCL);
        drive(v);
        @(posedge clk_SCL);
        model_step(v);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " state"}, 32'(daa_state), 32'(m_state));
        chk({tag, " cnt"}, 32'(id64_cnt), 32'(cnt_of_pos(m_pos)));
        chk({tag, " active"}, 32'(daa_active), 32'(m_act));
        chk({tag, " lost"}, 32'(daa_lost), 32'(m_lost));
        chk({tag, " win"}, 32'(daa_win), 32'(m_win));
`ifdef I3C_DAA_RETRY_CNT_EN
        chk({tag, " gaveup"}, 32'(daa_retry_gaveup), 32'(m_gave));
`endif
    endtask

    task automatic step(input in_t v, input string tag);
        apply(v);
        check_model(tag);
    endtask

    // Clean arbitration bits: we drive a random bit and the bus echoes it.
    task automatic run_bits(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            step(mk(1, 0, 0, 0, b, 1, b, 0), "bits");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " state"}, 32'(daa_state), 32'd0);
        chk({tag, " cnt"}, 32'(id64_cnt), 32'h7F);
        chk({tag, " active"}, 32'(daa_active), 32'd0);
        chk({tag, " lost"}, 32'(daa_lost), 32'd0);
        chk({tag, " win"}, 32'(daa_win), 32'd0);
    endtask

    vec_t tbl[11];
    in_t  rv;

    initial begin
        tbl[0]  = '{mk(1,0,0,0,0,0,0,0), S_WAIT, 'h7F, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{mk(1,1,0,0,0,0,0,0), S_WAIT, 'h7F, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{mk(1,0,1,0,0,0,0,0), S_ID,   'h7F, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{mk(1,0,0,0,1,1,1,0), S_ID,   'h7E, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{mk(1,0,0,0,0,1,0,0), S_ID,   'h7D, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{mk(1,0,0,0,0,1,1,0), S_LOST, 'h7D, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{mk(1,0,0,0,0,0,0,0), S_LOST, 'h7D, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{mk(1,1,0,0,0,0,0,0), S_WAIT, 'h7F, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{mk(1,0,0,1,0,0,0,0), S_DONE, 'h7F, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{mk(0,0,0,0,0,0,0,0), S_IDLE, 'h7F, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{mk(1,0,0,1,0,0,0,0), S_IDLE, 'h7F, 1'b0, 1'b0, 1'b0};

        RSTn = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0));
        #12;
        chk_reset_vals("reset");
        @(negedge clk_SCL);
        RSTn = 1'b1;

        // Constant vector table.
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].in);
            chk($sformatf("vec%0d state", i), 32'(daa_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d cnt", i), 32'(id64_cnt), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d active", i), 32'(daa_active), 32'(tbl[i].act));
            chk($sformatf("vec%0d lost", i), 32'(daa_lost), 32'(tbl[i].lost));
            chk($sformatf("vec%0d win", i), 32'(daa_win), 32'(tbl[i].win));
        end

        // Winning round: ID 7F..40, DA 0F..08, ACK at 07.
        step(mk(1,0,0,0,0,0,0,0), "win_arm");
        step(mk(1,0,1,0,0,0,0,0), "win_hdr");
        run_bits(72);
        chk("win pre_ack state", 32'(daa_state), 32'(S_ACK));
        chk("win pre_ack cnt", 32'(id64_cnt), 32'h07);
        apply(mk(1,0,0,0,0,0,0,1));
        check_model("win_ack");
        chk("win pulse", 32'(daa_win), 32'd1);
        chk("win cnt", 32'(id64_cnt), 32'h07);
        chk("win state", 32'(daa_state), 32'(S_DONE));
        chk("win active", 32'(daa_active), 32'd0);
        apply(mk(1,0,0,0,0,0,0,0));
        check_model("win_hold");
        chk("win pulse_end", 32'(daa_win), 32'd0);
        step(mk(0,0,0,0,0,0,0,0), "win_exit");

        // Arbitration loss at bit 0x50, then re-arbitration after Sr.
        step(mk(1,0,0,0,0,0,0,0), "loss_arm");
        step(mk(1,0,1,0,0,0,0,0), "loss_hdr");
        run_bits(47);
        chk("loss at_cnt", 32'(id64_cnt), 32'h50);
        apply(mk(1,0,0,0,0,1,1,0));
        check_model("loss_bit");
        chk("loss lost", 32'(daa_lost), 32'd1);
        chk("loss active", 32'(daa_active), 32'd0);
        chk("loss state", 32'(daa_state), 32'(S_LOST));
        step(mk(1,1,0,0,0,0,0,0), "loss_sr");
        chk("loss sr_clear", 32'(daa_lost), 32'd0);
        apply(mk(1,0,1,0,0,0,0,0));
        check_model("loss_rehdr");
        chk("loss restart cnt", 32'(id64_cnt), 32'h7F);
        chk("loss restart state", 32'(daa_state), 32'(S_ID));
        step(mk(0,0,0,0,0,0,0,0), "loss_exit");

        // Bad parity: NACK back to WAIT_HDR, next round wins.
        step(mk(1,0,0,0,0,0,0,0), "par_arm");
        step(mk(1,0,1,0,0,0,0,0), "par_hdr");
        run_bits(72);
        apply(mk(1,0,0,0,0,0,0,0));
        check_model("par_nack");
        chk("par no_win", 32'(daa_win), 32'd0);
        chk("par state", 32'(daa_state), 32'(S_WAIT));
        step(mk(1,1,0,0,0,0,0,0), "par_sr");
        step(mk(1,0,1,0,0,0,0,0), "par_hdr2");
        run_bits(72);
        apply(mk(1,0,0,0,0,0,0,1));
        check_model("par_ack2");
        chk("par retry_win", 32'(daa_win), 32'd1);
        step(mk(0,0,0,0,0,0,0,0), "par_exit");

        // Abort during DA at counter 0x0C.
        step(mk(1,0,0,0,0,0,0,0), "abort_arm");
        step(mk(1,0,1,0,0,0,0,0), "abort_hdr");
        run_bits(67);
        chk("abort at_cnt", 32'(id64_cnt), 32'h0C);
        apply(mk(0,0,0,0,0,0,0,0));
        check_model("abort");
        chk("abort state", 32'(daa_state), 32'(S_IDLE));
        chk("abort cnt", 32'(id64_cnt), 32'h7F);
        chk("abort active", 32'(daa_active), 32'd0);

        // Asynchronous reset mid-ID at counter 0x60.
        step(mk(1,0,0,0,0,0,0,0), "rst_arm");
        step(mk(1,0,1,0,0,0,0,0), "rst_hdr");
        run_bits(31);
        chk("rst at_cnt", 32'(id64_cnt), 32'h60);
        #2;
        RSTn = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0));
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk_SCL);
        @(negedge clk_SCL);
        RSTn = 1'b1;

`ifdef I3C_DAA_RETRY_CNT_EN
        // Three consecutive parity NACKs exhaust the retry budget.
        for (int r = 0; r < 3; r++) begin
            step(mk(1,0,0,0,0,0,0,0), "rty_arm");
            step(mk(1,0,1,0,0,0,0,0), "rty_hdr");
            run_bits(72);
            apply(mk(1,0,0,0,0,0,0,0));
            check_model("rty_nack");
            chk($sformatf("rty%0d gaveup", r), 32'(daa_retry_gaveup), (r == 2) ? 32'd1 : 32'd0);
            chk($sformatf("rty%0d state", r), 32'(daa_state), (r == 2) ? 32'(S_DONE) : 32'(S_WAIT));
            chk($sformatf("rty%0d win", r), 32'(daa_win), 32'd0);
        end
        step(mk(0,0,0,0,0,0,0,0), "rty_exit");
        chk("rty gaveup_clear", 32'(daa_retry_gaveup), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rv.ccc  = ($urandom_range(0, 149) != 0);
            rv.sr   = ($urandom_range(0, 39) == 0);
            rv.hdr  = ($urandom_range(0, 3) == 0);
            rv.das  = ($urandom_range(0, 199) == 0);
            rv.drv  = 1'($urandom_range(0, 1));
            rv.dbit = 1'($urandom_range(0, 1));
            rv.sda  = ($urandom_range(0, 19) == 0) ? ~rv.dbit : rv.dbit;
            rv.par  = ($urandom_range(0, 2) != 0);
            step(rv, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
